// File: rtl/fm_gd_loader.sv
// fm_gd_loader: streams words round-robin into NUM_COL fm buffers, then NUM_COL guard buffers.
// Define LOADER_STALL_CNT_EN to build the input-starvation counter on stall_cnt.
module fm_gd_loader #(
    parameter int NUM_COL = 4,
    parameter int DEPTH = 256,
    parameter int DATA_W = 72,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [AW:0]               cmd_fm_len,
    input  logic [AW:0]               cmd_gd_len,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_W-1:0]         in_data,
    output logic [NUM_COL*AW-1:0]     load_fm_wr_addr,
    output logic [NUM_COL*DATA_W-1:0] load_fm_din,
    output logic [NUM_COL-1:0]        load_fm_wr_en,
    output logic [NUM_COL*AW-1:0]     load_gd_wr_addr,
    output logic [NUM_COL*DATA_W-1:0] load_gd_din,
    output logic [NUM_COL-1:0]        load_gd_wr_en,
    output logic                      busy,
    output logic                      done,
    output logic [15:0]               stall_cnt
);
    localparam int CW = NUM_COL > 1 ? $clog2(NUM_COL) : 1;

    typedef enum logic [1:0] {IDLE, FM, GD, FIN} state_t;

    state_t                            r_state, w_next;
    logic [AW:0]                       r_fm_len, r_gd_len;
    logic [AW:0]                       w_fm_len, w_gd_len, w_len;
    logic [CW-1:0]                     r_col;
    logic [AW-1:0]                     r_addr;
    logic                              w_accept, w_xfer, w_last;
    logic [NUM_COL-1:0][AW-1:0]        r_fm_addr, r_gd_addr;
    logic [NUM_COL-1:0][DATA_W-1:0]    r_fm_din, r_gd_din;
    logic [NUM_COL-1:0]                r_fm_wr_en, r_gd_wr_en;

    assign w_fm_len = (cmd_fm_len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : cmd_fm_len;
    assign w_gd_len = (cmd_gd_len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : cmd_gd_len;
    assign cmd_ready = r_state == IDLE;
    assign in_ready = r_state == FM || r_state == GD;
    assign busy = r_state != IDLE;
    assign done = r_state == FIN;
    assign w_accept = cmd_valid && cmd_ready;
    assign w_xfer = in_valid && in_ready;
    assign w_len = r_state == FM ? r_fm_len : r_gd_len;
    // Last word of a phase: final column of the final row of that phase.
    assign w_last = r_col == CW'(NUM_COL - 1) && {1'b0, r_addr} == w_len - 1'b1;

    assign load_fm_wr_addr = r_fm_addr;
    assign load_fm_din = r_fm_din;
    assign load_fm_wr_en = r_fm_wr_en;
    assign load_gd_wr_addr = r_gd_addr;
    assign load_gd_din = r_gd_din;
    assign load_gd_wr_en = r_gd_wr_en;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (w_accept) w_next = w_fm_len != '0 ? FM : w_gd_len != '0 ? GD : FIN;
            FM:   if (w_xfer && w_last) w_next = r_gd_len != '0 ? GD : FIN;
            GD:   if (w_xfer && w_last) w_next = FIN;
            FIN:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_fm_len <= '0;
            r_gd_len <= '0;
            r_col <= '0;
            r_addr <= '0;
            r_fm_addr <= '0;
            r_gd_addr <= '0;
            r_fm_din <= '0;
            r_gd_din <= '0;
            r_fm_wr_en <= '0;
            r_gd_wr_en <= '0;
        end else begin
            r_state <= w_next;
            r_fm_wr_en <= '0;
            r_gd_wr_en <= '0;
            if (w_accept) begin
                r_fm_len <= w_fm_len;
                r_gd_len <= w_gd_len;
                r_col <= '0;
                r_addr <= '0;
            end
            if (w_xfer) begin
                if (w_last) begin
                    r_col <= '0;
                    r_addr <= '0;
                end else if (r_col == CW'(NUM_COL - 1)) begin
                    r_col <= '0;
                    r_addr <= r_addr + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
                if (r_state == FM) begin
                    r_fm_wr_en[r_col] <= 1'b1;
                    r_fm_addr[r_col] <= r_addr;
                    r_fm_din[r_col] <= in_data;
                end else begin
                    r_gd_wr_en[r_col] <= 1'b1;
                    r_gd_addr[r_col] <= r_addr;
                    r_gd_din[r_col] <= in_data;
                end
            end
        end
    end

`ifdef LOADER_STALL_CNT_EN
    logic [15:0] r_stall;

    always_ff @(posedge clk) begin
        if (rst || w_accept)
            r_stall <= '0;
        else if (in_ready && !in_valid && r_stall != 16'hFFFF)
            r_stall <= r_stall + 16'd1;
    end

    assign stall_cnt = r_stall;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fm_gd_loader.sv
// tb_fm_gd_loader: directed vector table plus hand-written gap, reset and busy-command sequences.
module tb_fm_gd_loader;
    localparam int NC = 4;
    localparam int D = 16;
    localparam int W = 72;
    localparam int AW = 4;
    localparam int VW = NC * W;

    typedef struct {
        int fl;
        int gl;
        int fm_w;
        int gd_w;
        int lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cmd_valid = 1'b0;
    logic in_valid = 1'b0;
    logic [AW:0] cmd_fm_len = '0;
    logic [AW:0] cmd_gd_len = '0;
    logic [W-1:0] in_data = '0;
    logic cmd_ready, in_ready, busy, done;
    logic [NC*AW-1:0] load_fm_wr_addr, load_gd_wr_addr;
    logic [NC*W-1:0] load_fm_din, load_gd_din;
    logic [NC-1:0] load_fm_wr_en, load_gd_wr_en;
    logic [15:0] stall_cnt;

    fm_gd_loader #(.NUM_COL(NC), .DEPTH(D), .DATA_W(W)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_fm_len(cmd_fm_len), .cmd_gd_len(cmd_gd_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .load_fm_wr_addr(load_fm_wr_addr), .load_fm_din(load_fm_din), .load_fm_wr_en(load_fm_wr_en),
        .load_gd_wr_addr(load_gd_wr_addr), .load_gd_din(load_gd_din), .load_gd_wr_en(load_gd_wr_en),
        .busy(busy), .done(done), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_tot = 0;
    bit m_idle = 1'b1;
    bit m_stream = 1'b0;
    bit m_done = 1'b0;
    int m_n = 0;
    int m_tot = 0;
    int m_fl = 0;
    int m_stall = 0;
    logic [AW-1:0] e_fa[NC];
    logic [AW-1:0] e_ga[NC];
    logic [W-1:0] e_fd[NC];
    logic [W-1:0] e_gd[NC];
    logic [NC-1:0] e_fen = '0;
    logic [NC-1:0] e_gen = '0;
    int fm_wr_cnt = 0;
    int gd_wr_cnt = 0;
    int done_cnt = 0;
    vec_t tv[6];

    task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        n_tot++;
        if (act !== exp) $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        else n_pass++;
    endtask

    function automatic int clampl(input logic [AW:0] v);
        return int'(v) > D ? D : int'(v);
    endfunction

    task automatic check_outs();
        logic [NC*AW-1:0] fa, ga;
        logic [NC*W-1:0] fd, gd;
        for (int c = 0; c < NC; c++) begin
            fa[c*AW +: AW] = e_fa[c];
            ga[c*AW +: AW] = e_ga[c];
            fd[c*W +: W] = e_fd[c];
            gd[c*W +: W] = e_gd[c];
        end
        chk("cmd_ready", VW'(cmd_ready), VW'(m_idle));
        chk("in_ready", VW'(in_ready), VW'(m_stream));
        chk("busy", VW'(busy), VW'(!m_idle));
        chk("done", VW'(done), VW'(m_done));
        chk("fm_wr_en", VW'(load_fm_wr_en), VW'(e_fen));
        chk("gd_wr_en", VW'(load_gd_wr_en), VW'(e_gen));
        chk("fm_addr", VW'(load_fm_wr_addr), VW'(fa));
        chk("gd_addr", VW'(load_gd_wr_addr), VW'(ga));
        chk("fm_din", load_fm_din, fd);
        chk("gd_din", load_gd_din, gd);
`ifdef LOADER_STALL_CNT_EN
        chk("stall_cnt", VW'(stall_cnt), VW'(m_stall));
`else
        chk("stall_cnt", VW'(stall_cnt), VW'(0));
`endif
        fm_wr_cnt += $countones(load_fm_wr_en);
        gd_wr_cnt += $countones(load_gd_wr_en);
        done_cnt += int'(done);
    endtask

    // Advance one clock: update the behavioural model from this cycle's inputs, then check the next cycle.
    task automatic tick();
        bit acc, xf, nd, g;
        int k, fl, gl;
        acc = cmd_valid && m_idle;
        xf = in_valid && m_stream;
        nd = 1'b0;
        e_fen = '0;
        e_gen = '0;
        if (m_stream && !in_valid && m_stall < 65535) m_stall++;
        if (xf) begin
            g = m_n >= m_fl * NC;
            k = g ? m_n - m_fl * NC : m_n;
            if (g) begin
                e_gen[k % NC] = 1'b1;
                e_ga[k % NC] = AW'(k / NC);
                e_gd[k % NC] = in_data;
            end else begin
                e_fen[k % NC] = 1'b1;
                e_fa[k % NC] = AW'(k / NC);
                e_fd[k % NC] = in_data;
            end
            m_n++;
            if (m_n == m_tot) begin
                m_stream = 1'b0;
                nd = 1'b1;
            end
        end
        if (m_done) m_idle = 1'b1;
        if (acc) begin
            fl = clampl(cmd_fm_len);
            gl = clampl(cmd_gd_len);
            m_fl = fl;
            m_tot = (fl + gl) * NC;
            m_n = 0;
            m_idle = 1'b0;
            m_stream = m_tot > 0;
            nd = m_tot == 0;
            m_stall = 0;
        end
        m_done = nd;
        @(posedge clk);
        #1;
        check_outs();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cmd_valid = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_idle = 1'b1;
        m_stream = 1'b0;
        m_done = 1'b0;
        m_stall = 0;
        e_fen = '0;
        e_gen = '0;
        for (int c = 0; c < NC; c++) begin
            e_fa[c] = '0;
            e_ga[c] = '0;
            e_fd[c] = '0;
            e_gd[c] = '0;
        end
        check_outs();
    endtask

    task automatic clr_cnts();
        fm_wr_cnt = 0;
        gd_wr_cnt = 0;
        done_cnt = 0;
    endtask

    initial begin
        int cyc;
        logic [6:0] pat;
        tv[0] = '{2, 1, 8, 4, 12};
        tv[1] = '{0, 0, 0, 0, 0};
        tv[2] = '{20, 0, 64, 0, 64};
        tv[3] = '{0, 3, 0, 12, 12};
        tv[4] = '{1, 1, 4, 4, 8};
        tv[5] = '{31, 16, 64, 64, 128};
        do_reset();

        for (int i = 0; i < 6; i++) begin
            clr_cnts();
            cmd_fm_len = (AW+1)'(tv[i].fl);
            cmd_gd_len = (AW+1)'(tv[i].gl);
            cmd_valid = 1'b1;
            tick();
            cmd_valid = 1'b0;
            cyc = 0;
            in_valid = 1'b1;
            while (!done && cyc < 300) begin
                in_data = {8'(i), 32'hD000_0000, 32'(cyc)};
                tick();
                cyc++;
            end
            in_valid = 1'b0;
            chk($sformatf("vec%0d_fm_writes", i), VW'(fm_wr_cnt), VW'(tv[i].fm_w));
            chk($sformatf("vec%0d_gd_writes", i), VW'(gd_wr_cnt), VW'(tv[i].gd_w));
            chk($sformatf("vec%0d_latency", i), VW'(cyc), VW'(tv[i].lat));
            chk($sformatf("vec%0d_done_pulses", i), VW'(done_cnt), VW'(1));
            tick();
        end
        chk("clamp_last_fm_addr", VW'(load_fm_wr_addr[3*AW +: AW]), VW'(15));

        clr_cnts();
        pat = 7'b1011001;
        cmd_fm_len = 5'd1;
        cmd_gd_len = 5'd0;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        for (int j = 0; j < 7; j++) begin
            in_valid = pat[j];
            in_data = {8'hAA, 32'h0, 32'(j)};
            tick();
        end
        in_valid = 1'b0;
        chk("gap_done", VW'(done), VW'(1));
        chk("gap_writes", VW'(fm_wr_cnt), VW'(4));
`ifdef LOADER_STALL_CNT_EN
        chk("gap_stall", VW'(stall_cnt), VW'(3));
`else
        chk("gap_stall", VW'(stall_cnt), VW'(0));
`endif
        tick();

        clr_cnts();
        cmd_fm_len = 5'd2;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        in_valid = 1'b1;
        for (int j = 0; j < 5; j++) begin
            in_data = {8'hBB, 32'h0, 32'(j)};
            tick();
        end
        do_reset();
        chk("rst_busy", VW'(busy), VW'(0));
        chk("rst_wr_en", VW'(load_fm_wr_en), VW'(0));
        for (int j = 0; j < 3; j++) tick();
        chk("rst_no_done", VW'(done_cnt), VW'(0));
        cmd_fm_len = 5'd1;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        in_valid = 1'b1;
        in_data = {8'hCC, 64'h0};
        tick();
        chk("post_rst_col0", VW'(load_fm_wr_en), VW'(4'b0001));
        chk("post_rst_addr0", VW'(load_fm_wr_addr[AW-1:0]), VW'(0));
        for (int j = 1; j < 4; j++) begin
            in_data = {8'hCC, 32'h0, 32'(j)};
            tick();
        end
        in_valid = 1'b0;
        chk("post_rst_done", VW'(done), VW'(1));
        tick();

        cmd_fm_len = 5'd1;
        cmd_gd_len = 5'd0;
        cmd_valid = 1'b1;
        tick();
        in_valid = 1'b1;
        for (int j = 0; j < 4; j++) begin
            in_data = {8'hDD, 32'h0, 32'(j)};
            tick();
            chk("busy_cmd_ready_low", VW'(cmd_ready), VW'(0));
        end
        in_valid = 1'b0;
        chk("busy_cmd_done", VW'(done), VW'(1));
        tick();
        chk("busy_cmd_idle", VW'(cmd_ready), VW'(1));
        tick();
        chk("busy_cmd_second_accept", VW'(busy), VW'(1));
        cmd_valid = 1'b0;
        in_valid = 1'b1;
        for (int j = 0; j < 4; j++) begin
            in_data = {8'hEE, 32'h0, 32'(j)};
            tick();
        end
        in_valid = 1'b0;
        chk("second_cmd_done", VW'(done), VW'(1));
        tick();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
